// File: rtl/bsg_fifo_pkg.sv
// Shared constants and checks for the one-hot-pointer FIFO family.
// Holds the minimum depth and a pointer one-hotness assertion macro.
package bsg_fifo_pkg;
  localparam int unsigned bsg_fifo_min_els_lp = 2;
endpackage

`ifndef BSG_FIFO_ASSERT_ONE_HOT
`define BSG_FIFO_ASSERT_ONE_HOT(clk, en, sig) \
  assert property (@(posedge clk) disable iff (!(en)) $onehot(sig));
`endif

// File: rtl/bsg_counter_clear_up_one_hot.sv
// Rotating one-hot up-counter with synchronous reset and clear.
// Ports: clk_i, reset_i, clear_i, up_i; count_r_o is the one-hot state.
module bsg_counter_clear_up_one_hot #(
  parameter int width_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_r_o
);

  logic [width_p-1:0] rot;

  assign rot = {count_r_o[width_p-2:0], count_r_o[width_p-1]};

  always_ff @(posedge clk_i) begin
    if (reset_i | clear_i)
      count_r_o <= width_p'(1);
    else if (up_i)
      count_r_o <= rot;
  end

endmodule

// File: rtl/bsg_fifo_1r1w_one_hot_ptr.sv
// 1R1W FIFO with one-hot read/write pointers (valid/ready in, valid/yumi out).
// Ports: clk_i, reset_n_i, clear_i, v_i/data_i/ready_o, v_o/data_o/yumi_i.
module bsg_fifo_1r1w_one_hot_ptr
  import bsg_fifo_pkg::*;
#(
  parameter int width_p = 8,
  parameter int els_p   = 17
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               clear_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  if (els_p < int'(bsg_fifo_min_els_lp)) begin : g_bad_els
    $error("els_p below minimum depth");
  end

  logic [els_p-1:0]   wptr_r;
  logic [els_p-1:0]   rptr_r;
  logic               last_enq_r;
  logic               enq;
  logic               deq;
  logic               same;
  logic               flush;
  logic [width_p-1:0] mem [els_p];

  assign same    = (wptr_r == rptr_r);
  assign ready_o = ~(same & last_enq_r);
  assign v_o     = ~(same & ~last_enq_r);
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i;
  assign flush   = ~reset_n_i | clear_i;

  bsg_counter_clear_up_one_hot #(
    .width_p (els_p)
  ) u_wptr (
    .clk_i     (clk_i),
    .reset_i   (~reset_n_i),
    .clear_i   (clear_i),
    .up_i      (enq),
    .count_r_o (wptr_r)
  );

  bsg_counter_clear_up_one_hot #(
    .width_p (els_p)
  ) u_rptr (
    .clk_i     (clk_i),
    .reset_i   (~reset_n_i),
    .clear_i   (clear_i),
    .up_i      (deq),
    .count_r_o (rptr_r)
  );

  // A write in a flush cycle is dropped, so the slot stays untouched.
  always_ff @(posedge clk_i) begin
    if (enq & ~flush) begin
      for (int k = 0; k < els_p; k++)
        if (wptr_r[k])
          mem[k] <= data_i;
    end
  end

  // Equal pointers mean full if the last net change was an enqueue.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i)
      last_enq_r <= 1'b0;
    else if (clear_i)
      last_enq_r <= 1'b0;
    else if (enq != deq)
      last_enq_r <= enq;
  end

  always_comb begin
    data_o = '0;
    for (int k = 0; k < els_p; k++)
      data_o = data_o | (mem[k] & {width_p{rptr_r[k]}});
  end

  `BSG_FIFO_ASSERT_ONE_HOT(clk_i, reset_n_i, wptr_r)
  `BSG_FIFO_ASSERT_ONE_HOT(clk_i, reset_n_i, rptr_r)

endmodule

// File: tb/tb_bsg_fifo_1r1w_one_hot_ptr.sv
// Testbench for bsg_fifo_1r1w_one_hot_ptr: vectors, corner cases, random.
// Drives a 4-entry and a default 17-entry instance.
module tb_bsg_fifo_1r1w_one_hot_ptr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic       clear;

  logic       v4, y4, r4, vo4;
  logic [7:0] d4, q4;

  logic       v17, y17, r17, vo17;
  logic [7:0] d17, q17;

  int n_cmp = 0;
  int n_err = 0;

  bsg_fifo_1r1w_one_hot_ptr #(
    .width_p (8),
    .els_p   (4)
  ) u4 (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .clear_i   (clear),
    .v_i       (v4),
    .data_i    (d4),
    .ready_o   (r4),
    .v_o       (vo4),
    .data_o    (q4),
    .yumi_i    (y4)
  );

  bsg_fifo_1r1w_one_hot_ptr u17 (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .clear_i   (clear),
    .v_i       (v17),
    .data_i    (d17),
    .ready_o   (r17),
    .v_o       (vo17),
    .data_o    (q17),
    .yumi_i    (y17)
  );

  a_yumi4 : assert property (@(posedge clk) disable iff (!reset_n)
    !(y4 && !vo4));
  a_yumi17 : assert property (@(posedge clk) disable iff (!reset_n)
    !(y17 && !vo17));

  typedef struct {
    bit         v;
    bit         y;
    logic [7:0] d;
    bit         er;
    bit         ev;
    bit         cd;
    logic [7:0] ed;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv4(input bit v, input bit y, input logic [7:0] d);
    v4 = v;
    y4 = y;
    d4 = d;
  endtask

  function automatic vec_t mk(bit v, bit y, logic [7:0] d, bit er,
                              bit ev, bit cd, logic [7:0] ed);
    vec_t t;
    t.v = v; t.y = y; t.d = d;
    t.er = er; t.ev = ev; t.cd = cd; t.ed = ed;
    return t;
  endfunction

  logic [7:0] q[$];
  logic [3:0] oh;

  initial begin
    // fill then drain, refused fifth write
    vecs.push_back(mk(1, 0, 8'hA0, 1, 1, 1, 8'hA0));
    vecs.push_back(mk(1, 0, 8'hA1, 1, 1, 1, 8'hA0));
    vecs.push_back(mk(1, 0, 8'hA2, 1, 1, 1, 8'hA0));
    vecs.push_back(mk(1, 0, 8'hA3, 0, 1, 1, 8'hA0));
    vecs.push_back(mk(1, 0, 8'hFF, 0, 1, 1, 8'hA0));
    vecs.push_back(mk(0, 1, 8'h00, 1, 1, 1, 8'hA1));
    vecs.push_back(mk(0, 1, 8'h00, 1, 1, 1, 8'hA2));
    vecs.push_back(mk(0, 1, 8'h00, 1, 1, 1, 8'hA3));
    vecs.push_back(mk(0, 1, 8'h00, 1, 0, 0, 8'h00));
    // full with both requests: only the dequeue happens
    vecs.push_back(mk(1, 0, 8'hC0, 1, 1, 1, 8'hC0));
    vecs.push_back(mk(1, 0, 8'hC1, 1, 1, 1, 8'hC0));
    vecs.push_back(mk(1, 0, 8'hC2, 1, 1, 1, 8'hC0));
    vecs.push_back(mk(1, 0, 8'hC3, 0, 1, 1, 8'hC0));
    vecs.push_back(mk(1, 1, 8'hEE, 1, 1, 1, 8'hC1));
    vecs.push_back(mk(0, 1, 8'h00, 1, 1, 1, 8'hC2));
    vecs.push_back(mk(0, 1, 8'h00, 1, 1, 1, 8'hC3));
    vecs.push_back(mk(0, 1, 8'h00, 1, 0, 0, 8'h00));

    reset_n = 1'b0;
    clear   = 1'b0;
    drv4(0, 0, 8'h00);
    v17 = 1'b0; y17 = 1'b0; d17 = 8'h00;
    step();
    step();
    reset_n = 1'b1;
    step();

    chk("rst_ready4", 32'(r4), 32'd1);
    chk("rst_v4", 32'(vo4), 32'd0);
    chk("rst_wptr4", 32'(u4.wptr_r), 32'h1);
    chk("rst_rptr4", 32'(u4.rptr_r), 32'h1);
    chk("rst_ready17", 32'(r17), 32'd1);
    chk("rst_v17", 32'(vo17), 32'd0);
    chk("rst_wptr17", 32'(u17.wptr_r), 32'h00001);
    chk("rst_rptr17", 32'(u17.rptr_r), 32'h00001);

    foreach (vecs[i]) begin
      drv4(vecs[i].v, vecs[i].y, vecs[i].d);
      step();
      chk($sformatf("vec%0d_ready", i), 32'(r4), 32'(vecs[i].er));
      chk($sformatf("vec%0d_v", i), 32'(vo4), 32'(vecs[i].ev));
      if (vecs[i].cd)
        chk($sformatf("vec%0d_data", i), 32'(q4), 32'(vecs[i].ed));
    end
    drv4(0, 0, 8'h00);

    // clear mid-stream with a concurrent write
    for (int i = 0; i < 3; i++) begin
      drv4(1, 0, 8'(8'hD0 + i));
      step();
    end
    chk("clr_pre_v", 32'(vo4), 32'd1);
    clear = 1'b1;
    drv4(1, 0, 8'h55);
    step();
    clear = 1'b0;
    drv4(0, 0, 8'h00);
    chk("clr_v", 32'(vo4), 32'd0);
    chk("clr_ready", 32'(r4), 32'd1);
    chk("clr_wptr", 32'(u4.wptr_r), 32'h1);
    chk("clr_rptr", 32'(u4.rptr_r), 32'h1);
    step();
    chk("clr_idle_v", 32'(vo4), 32'd0);
    drv4(1, 0, 8'h66);
    step();
    drv4(0, 0, 8'h00);
    chk("clr_next_v", 32'(vo4), 32'd1);
    chk("clr_next_data", 32'(q4), 32'h66);
    drv4(0, 1, 8'h00);
    step();
    drv4(0, 0, 8'h00);
    chk("clr_drain_v", 32'(vo4), 32'd0);

    // wrap-around: one resident entry, simultaneous enq/deq
    clear = 1'b1;
    step();
    clear = 1'b0;
    drv4(1, 0, 8'hB0);
    step();
    for (int i = 1; i <= 10; i++) begin
      drv4(1, 1, 8'(8'hB0 + i));
      step();
      oh = 4'b0001 << (i % 4);
      chk($sformatf("wrap%0d_data", i), 32'(q4), 32'(8'hB0 + i));
      chk($sformatf("wrap%0d_v", i), 32'(vo4), 32'd1);
      chk($sformatf("wrap%0d_ready", i), 32'(r4), 32'd1);
      chk($sformatf("wrap%0d_rptr", i), 32'(u4.rptr_r), 32'(oh));
    end
    drv4(0, 1, 8'h00);
    step();
    drv4(0, 0, 8'h00);
    chk("wrap_drain_v", 32'(vo4), 32'd0);

    // 17-deep instance: fill to full, then drain in order
    for (int i = 0; i < 17; i++) begin
      v17 = 1'b1;
      d17 = 8'(i + 8'h10);
      step();
    end
    v17 = 1'b1;
    d17 = 8'hFF;
    step();
    v17 = 1'b0;
    chk("full17_ready", 32'(r17), 32'd0);
    for (int i = 0; i < 17; i++) begin
      chk($sformatf("drain17_%0d", i), 32'(q17), 32'(i + 8'h10));
      y17 = 1'b1;
      step();
    end
    y17 = 1'b0;
    chk("drain17_v", 32'(vo17), 32'd0);
    chk("drain17_ready", 32'(r17), 32'd1);

    // random traffic against a queue model
    clear = 1'b1;
    step();
    clear = 1'b0;
    q.delete();
    for (int c = 0; c < 10000; c++) begin
      bit v, y, cl;
      logic [7:0] d;
      chk("rnd_v", 32'(vo4), 32'(q.size() != 0));
      chk("rnd_ready", 32'(r4), 32'(q.size() < 4));
      if (q.size() != 0)
        chk("rnd_data", 32'(q4), 32'(q[0]));
      v  = ($urandom_range(0, 99) < 60);
      y  = (q.size() != 0) && ($urandom_range(0, 99) < 55);
      cl = ($urandom_range(0, 299) == 0);
      d  = 8'($urandom);
      drv4(v, y, d);
      clear = cl;
      if (cl) begin
        q.delete();
      end else begin
        bit acc;
        acc = v && (q.size() < 4);
        if (y) void'(q.pop_front());
        if (acc) q.push_back(d);
      end
      step();
    end
    clear = 1'b0;
    drv4(0, 0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bsg_fifo_1r1w_one_hot_ptr.md
# bsg_fifo_1r1w_one_hot_ptr

Small one-read/one-write FIFO whose read and write pointers are rotating one-hot counters. It is the consumer stage of the one-hot up-counter: each pointer is one counter instance, and its one-hot value directly drives write-enable decode and the AND-OR read mux, so no binary decode is needed. It uses the valid/ready-in, valid/yumi-out convention and sits between a producer and a consumer on the same clock.

## Interface
- `width_p`, default 8: data width in bits.
- `els_p`, default 17: number of entries, which equals the one-hot pointer width. Minimum is 2.
- `clk_i` input 1: clock. Everything updates on the rising edge.
- `reset_n_i` input 1: reset, synchronous and active-low.
- `clear_i` input 1: synchronous flush. Discards all contents.
- `v_i` input 1: write data is valid.
- `data_i` input `width_p`: write data.
- `ready_o` output 1: FIFO can accept data (not full).
- `v_o` output 1: read data is valid (not empty).
- `data_o` output `width_p`: head entry.
- `yumi_i` input 1: consumer takes the head this cycle. Legal only when `v_o`=1.

## Operation
- Enqueue occurs when `v_i & ready_o`:
  - `mem[k] <= data_i` for the single k where `wptr_r[k]`=1.
  - `wptr_r` rotates left by 1, so bit `els_p-1` wraps to bit 0.
- Dequeue occurs when `yumi_i` (which implies `v_o`): `rptr_r` rotates left by 1.
- Full/empty disambiguation:
  - `last_enq_r` is set on an enqueue without a dequeue, and cleared on a dequeue without an enqueue.
  - `full = (wptr_r == rptr_r) & last_enq_r`.
  - `empty = (wptr_r == rptr_r) & ~last_enq_r`.
- Outputs:
  - `ready_o = ~full`.
  - `v_o = ~empty`.
  - `data_o` = OR over k of (`mem[k]` masked by `rptr_r[k]`). It is a combinational function of registered state.
- Simultaneous enqueue and dequeue, not full and not empty: both pointers advance and `last_enq_r` is unchanged.
- Full with `v_i`=1 and `yumi_i`=1: `ready_o`=0, so only the dequeue occurs. There is no same-cycle pass-through when full.
- Empty with `v_i`=1: the enqueue occurs and `v_o` rises the next cycle. There is no bypass.
- Priority: `reset_n_i`=0 beats `clear_i`=1, which beats enqueue and dequeue.
  - Reset and clear behave identically: `wptr_r = rptr_r = 1` (bit 0), `last_enq_r` = 0.
  - `mem` contents are not reset (don't-care).
- Reset or clear in the middle of a stream drops all entries. Any `v_i` in that same cycle is not written.
- Pointer invariant: exactly one bit of each pointer is set at all times after the first reset edge.
- `yumi_i`=1 while `v_o`=0 is illegal. The bench asserts on it, and the RTL behaviour is undefined.

## Timing
- Reset values after a clock edge with `reset_n_i`=0: `ready_o`=1, `v_o`=0, `data_o` = `mem[0]` (undefined contents).
- Latency from write to visible at the head: 1 cycle when empty. Otherwise the entry appears after all older entries have been dequeued.
- `ready_o` and `v_o` depend only on registers. There is no combinational path from `v_i` or `yumi_i` to any output.
- Throughput: 1 enqueue plus 1 dequeue per cycle in steady state.
- `data_o` must be stable whenever `v_o`=1 and `yumi_i`=0.

## Structure
- Sub-modules:
  - Two instances of `bsg_counter_clear_up_one_hot`, with width = `els_p` and `reset_i = ~reset_n_i`.
  - Write pointer: `clear_i = clear_i`, `up_i` = enqueue.
  - Read pointer: `clear_i = clear_i`, `up_i` = dequeue.
  - Those instances supply the reset/clear-to-bit-0 and rotate-by-one behaviour.
- Storage is a flop array `mem[els_p][width_p]` local to this block, plus `last_enq_r`.
- Shared package `bsg_fifo_pkg`:
  - `localparam` minimum entries = 2.
  - An assertion macro for pointer one-hotness.
  - No typedefs; width is parameter-driven.

## Test plan
- Reset: hold `reset_n_i`=0 for 2 cycles, then release -> `ready_o`=1, `v_o`=0, both pointers = 17'h00001.
- Fill then drain (`els_p`=4): write 0xA0..0xA3 on consecutive cycles -> `ready_o`=0 after the 4th write. A 5th write of 0xFF is refused. Yumi 4 times -> `data_o` reads 0xA0, 0xA1, 0xA2, 0xA3 in order, then `v_o`=0.
- Wrap-around (`els_p`=4): 10 cycles of simultaneous enqueue/dequeue with one entry resident -> output order is preserved, the pointers wrap from 4'b1000 to 4'b0001, and occupancy stays at 1.
- Full with both requests: full, with `v_i`=1 and `yumi_i`=1 -> only the dequeue happens. Next cycle `ready_o`=1 and occupancy is 3.
- Clear mid-stream: 3 entries resident, `clear_i`=1 together with `v_i`=1 (0x55) -> next cycle `v_o`=0, `ready_o`=1, and 0x55 is never output.
- Random: 10k cycles of random `v_i` and `yumi_i` (yumi only when `v_o`) against a queue model -> data matches, the one-hot assertion holds, and no overflow or underflow occurs.
